axis_reg_slice_ex: RTL and testbench
====================================

Name: axis_reg_slice_ex

Overview:
Parametrised AXI4-Stream register slice used to close timing on long data-route paths between systolic-array tiles and buffers. It generalises the single forward-register stage, adds a correct valid/ready handshake, and supports four modes:
- Bypass.
- Forward-registered.
- Backward-registered (skid).
- Fully registered.

It carries TDATA, TLAST and TUSER sideband, and exposes an occupancy count for debug.

Parameters:
DWIDTH, 32, TDATA width in bits (>=1)
UWIDTH, 1, TUSER width in bits (>=1)
MODE, 1, 0=bypass, 1=forward (m_* registered), 2=backward (s_in_tready registered), 3=full (both registered, two-entry buffer)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
s_in_tdata  in  DWIDTH  upstream data
s_in_tuser  in  UWIDTH  upstream sideband
s_in_tlast  in  1  upstream end-of-packet
s_in_tvalid  in  1  upstream valid
s_in_tready  out  1  slice can accept a beat
m_out_tdata  out  DWIDTH  downstream data
m_out_tuser  out  UWIDTH  downstream sideband
m_out_tlast  out  1  downstream end-of-packet
m_out_tvalid  out  1  downstream valid
m_out_tready  in  1  downstream ready
occupancy  out  2  beats currently held (0..2)

Behaviour:
- Transfer on a port occurs when tvalid & tready are both high at posedge clk. Beats are never dropped, duplicated or reordered. TDATA, TUSER and TLAST always travel together.
- Reset (rst_n=0 at posedge):
  - m_out_tvalid=0, m_out_tdata/tuser/tlast=0, occupancy=0.
  - s_in_tready=0 in MODE 2/3; in MODE 1 it follows its combinational equation, which evaluates to 1.
  - Reset mid-transfer discards all held beats; no partial beat may appear after reset.
- MODE 0:
  - All m_* = s_in_* and s_in_tready = m_out_tready, combinationally.
  - occupancy is tied to 0. Zero latency.
- MODE 1 (forward):
  - One output register.
  - s_in_tready = ~m_out_tvalid | m_out_tready (combinational).
  - On an input transfer, load the register and set m_out_tvalid=1.
  - Else, on an output transfer, clear m_out_tvalid.
  - Latency 1 cycle. Full throughput (1 beat/cycle).
  - m_* must stay stable while m_out_tvalid=1 and m_out_tready=0.
  - occupancy = m_out_tvalid.
- MODE 2 (backward/skid):
  - m_* driven combinationally from the input when the skid register is empty, otherwise from the skid register.
  - s_in_tready is registered and equals "skid empty".
  - If an input beat arrives while m_out_tready=0 and the skid register is empty, capture it into the skid register and drop s_in_tready the next cycle.
  - When m_out_tready=1 and the skid register is full: present the skid beat, clear the skid register, and raise s_in_tready the next cycle.
  - Latency 0 when empty. occupancy = skid full.
- MODE 3 (full):
  - Main register plus skid register. s_in_tready and m_* are all registered.
  - States: EMPTY(0), ONE(1), TWO(2). occupancy equals the state count.
  - EMPTY:
    - in -> ONE (main loaded).
  - ONE:
    - in & out -> ONE (main reloaded).
    - in & ~out -> TWO (skid loaded).
    - out & ~in -> EMPTY.
  - TWO:
    - out -> ONE (main <= skid). Input is impossible because s_in_tready=0.
  - s_in_tready = (state != TWO), registered.
  - m_out_tvalid = (state != EMPTY).
  - Latency 1 cycle. Full throughput in steady state.
- Simultaneous in/out transfer in any registered mode must not stall or lose a beat.
- Backpressure: at most 2 beats are accepted after m_out_tready falls (MODE 3); at most 1 extra beat in MODE 2.
- X on s_in_tdata while s_in_tvalid=0 must never propagate into a held register.

Test Plan:
1. MODE=1, stream 0x1..0x8 with m_out_tready=1 -> outputs 0x1..0x8 on consecutive cycles, first one 1 cycle after input; occupancy=1 throughout.
2. MODE=3, stream 0xA0..0xAF, m_out_tready low for cycles 4-6 -> s_in_tready falls after occupancy=2, exactly 2 beats held, output order 0xA0..0xAF with no gaps once ready returns.
3. MODE=2, input valid continuously, m_out_tready toggled 1010... -> same-cycle pass-through when skid empty, skid captures 1 beat, all 16 beats delivered in order.
4. Any mode, TLAST on every 4th beat with TUSER = beat index -> TLAST/TUSER arrive aligned with the matching TDATA.
5. MODE=3 with occupancy=2, assert rst_n=0 for 1 cycle -> m_out_tvalid=0, occupancy=0, s_in_tready=0 during reset and 1 on the following cycle; held beats never appear.
6. Random valid/ready (50%), 10k beats, all modes -> scoreboard matches exactly; throughput is 1 beat/cycle when both sides are always ready.

Source files
------------

// File: rtl/axis_reg_slice_ex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_reg_slice_ex : AXI4-Stream register slice, bypass/fwd/skid/full |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module axis_reg_slice_ex #(
  parameter int DWIDTH = 32,
  parameter int UWIDTH = 1,
  parameter int MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] s_in_tdata,
  input  logic [UWIDTH-1:0] s_in_tuser,
  input  logic              s_in_tlast,
  input  logic              s_in_tvalid,
  output logic              s_in_tready,
  output logic [DWIDTH-1:0] m_out_tdata,
  output logic [UWIDTH-1:0] m_out_tuser,
  output logic              m_out_tlast,
  output logic              m_out_tvalid,
  input  logic              m_out_tready,
  output logic [1:0]        occupancy
);

  localparam int c_PW = DWIDTH + UWIDTH + 1;

  logic [c_PW-1:0] w_s_pay;
  logic [c_PW-1:0] w_m_pay;
  logic            w_s_ready;
  logic            w_m_valid;
  logic [1:0]      w_occ;

  // Payload fields are packed together so they can never drift apart.
  assign w_s_pay = {s_in_tuser, s_in_tlast, s_in_tdata};
  assign {m_out_tuser, m_out_tlast, m_out_tdata} = w_m_pay;
  assign s_in_tready  = w_s_ready;
  assign m_out_tvalid = w_m_valid;
  assign occupancy    = w_occ;

  generate
    case (MODE)
      0: begin : g_bypass
        logic w_unused;
        assign w_unused  = clk ^ rst_n;
        assign w_m_pay   = w_s_pay;
        assign w_m_valid = s_in_tvalid;
        assign w_s_ready = m_out_tready;
        assign w_occ     = 2'd0;
      end

      1: begin : g_fwd
        logic            r_valid;
        logic [c_PW-1:0] r_pay;

        assign w_s_ready = ~r_valid | m_out_tready;
        assign w_m_valid = r_valid;
        assign w_m_pay   = r_pay;
        assign w_occ     = {1'b0, r_valid};

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_valid <= 1'b0;
            r_pay   <= '0;
          end else if (s_in_tvalid && w_s_ready) begin
            r_valid <= 1'b1;
            r_pay   <= w_s_pay;
          end else if (m_out_tready) begin
            r_valid <= 1'b0;
          end
        end
      end

      2: begin : g_skid
        logic            r_skid_valid;
        logic [c_PW-1:0] r_skid_pay;
        logic            r_ready;

        // Pass-through is gated by r_ready so nothing leaks out straight after reset.
        assign w_s_ready = r_ready;
        assign w_m_valid = r_skid_valid | (s_in_tvalid & r_ready);
        assign w_m_pay   = r_skid_valid ? r_skid_pay : (r_ready ? w_s_pay : '0);
        assign w_occ     = {1'b0, r_skid_valid};

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
            r_ready      <= 1'b0;
          end else if (!r_skid_valid) begin
            if (s_in_tvalid && r_ready && !m_out_tready) begin
              r_skid_valid <= 1'b1;
              r_skid_pay   <= w_s_pay;
              r_ready      <= 1'b0;
            end else begin
              r_ready      <= 1'b1;
            end
          end else if (m_out_tready) begin
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
          end
        end
      end

      default: begin : g_full
        typedef enum logic [1:0] {
          S_EMPTY = 2'd0,
          S_ONE   = 2'd1,
          S_TWO   = 2'd2
        } state_t;

        state_t          r_state;
        logic            r_m_valid;
        logic            r_s_ready;
        logic [c_PW-1:0] r_main;
        logic [c_PW-1:0] r_skid;
        logic            w_in;
        logic            w_out;

        assign w_in      = s_in_tvalid & r_s_ready;
        assign w_out     = r_m_valid & m_out_tready;
        assign w_s_ready = r_s_ready;
        assign w_m_valid = r_m_valid;
        assign w_m_pay   = r_main;
        assign w_occ     = r_state;

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b0;
            r_main    <= '0;
            r_skid    <= '0;
          end else begin
            case (r_state)
              S_EMPTY: begin
                r_s_ready <= 1'b1;
                if (w_in) begin
                  r_main    <= w_s_pay;
                  r_m_valid <= 1'b1;
                  r_state   <= S_ONE;
                end
              end
              S_ONE: begin
                if (w_in && w_out) begin
                  r_main <= w_s_pay;
                end else if (w_in) begin
                  r_skid    <= w_s_pay;
                  r_s_ready <= 1'b0;
                  r_state   <= S_TWO;
                end else if (w_out) begin
                  r_m_valid <= 1'b0;
                  r_state   <= S_EMPTY;
                end
              end
              S_TWO: begin
                if (w_out) begin
                  r_main    <= r_skid;
                  r_s_ready <= 1'b1;
                  r_state   <= S_ONE;
                end
              end
              default: begin
                r_state   <= S_EMPTY;
                r_m_valid <= 1'b0;
                r_s_ready <= 1'b0;
              end
            endcase
          end
        end
      end
    endcase
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_reg_slice_ex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_reg_slice_ex : bench driving one slice instance per MODE     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_axis_reg_slice_ex;

  logic        clk;
  logic        rst_n;
  logic [15:0] s_data  [4];
  logic [3:0]  s_user  [4];
  logic        s_last  [4];
  logic        s_valid [4];
  logic        m_ready [4];

  wire [3:0]  s_ready_w;
  wire [63:0] m_data_w;
  wire [15:0] m_user_w;
  wire [3:0]  m_last_w;
  wire [3:0]  m_valid_w;
  wire [7:0]  occ_w;

  int n_chk;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      axis_reg_slice_ex #(.DWIDTH(16), .UWIDTH(4), .MODE(g)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_in_tdata   (s_data[g]),
        .s_in_tuser   (s_user[g]),
        .s_in_tlast   (s_last[g]),
        .s_in_tvalid  (s_valid[g]),
        .s_in_tready  (s_ready_w[g]),
        .m_out_tdata  (m_data_w[g*16 +: 16]),
        .m_out_tuser  (m_user_w[g*4 +: 4]),
        .m_out_tlast  (m_last_w[g]),
        .m_out_tvalid (m_valid_w[g]),
        .m_out_tready (m_ready[g]),
        .occupancy    (occ_w[g*2 +: 2])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source holds each beat until accepted; sink checks beats against the sent sequence.
  // rmode: 0 ready always, 1 ready low on cycles 4..6, 2 ready on even cycles, 3 random.
  task automatic stream(input string tag, input int m, input logic [15:0] base, input int n,
                        input int rmode, input int vpct, output int cycles, output int max_occ);
    int          sent;
    int          got;
    int          c;
    logic        hold;
    logic [31:0] act_p;
    logic [31:0] exp_p;
    sent = 0; got = 0; c = 0; hold = 1'b0; cycles = 0; max_occ = 0;
    while (got < n && c < n * 16 + 64) begin
      @(posedge clk); #1;
      if (!hold) begin
        if (sent < n && $urandom_range(99) < vpct) begin
          s_valid[m] = 1'b1;
          s_data[m]  = 16'(base + 16'(sent));
          s_user[m]  = 4'(sent);
          s_last[m]  = (sent % 4 == 3);
          hold       = 1'b1;
        end else begin
          s_valid[m] = 1'b0;
          s_data[m]  = 16'($urandom);
          s_user[m]  = 4'($urandom);
          s_last[m]  = 1'($urandom);
        end
      end
      case (rmode)
        0:       m_ready[m] = 1'b1;
        1:       m_ready[m] = !(c >= 4 && c <= 6);
        2:       m_ready[m] = (c % 2 == 0);
        default: m_ready[m] = 1'($urandom_range(1));
      endcase
      #2;
      if (int'(occ_w[m*2 +: 2]) > max_occ) max_occ = int'(occ_w[m*2 +: 2]);
      if (s_valid[m] && s_ready_w[m]) begin
        sent++;
        hold = 1'b0;
      end
      if (m_valid_w[m] && m_ready[m]) begin
        act_p = {11'b0, m_user_w[m*4 +: 4], m_last_w[m], m_data_w[m*16 +: 16]};
        exp_p = {11'b0, 4'(got), (got % 4 == 3), 16'(base + 16'(got))};
        chk(tag, act_p, exp_p);
        got++;
        cycles = c + 1;
      end
      c++;
    end
    @(posedge clk); #1;
    s_valid[m] = 1'b0;
    m_ready[m] = 1'b0;
    if (got < n) chk({tag, "_timeout"}, 32'(got), 32'(n));
  endtask

  int cyc;
  int mocc;

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int m = 0; m < 4; m++) begin
      s_valid[m] = 1'b0;
      s_data[m]  = '0;
      s_user[m]  = '0;
      s_last[m]  = 1'b0;
      m_ready[m] = 1'b0;
    end

    // Reset values
    @(posedge clk); #3;
    for (int m = 1; m < 4; m++) begin
      chk("rst_valid", 32'(m_valid_w[m]), 32'd0);
      chk("rst_occ",   32'(occ_w[m*2 +: 2]), 32'd0);
      chk("rst_data",  32'(m_data_w[m*16 +: 16]), 32'd0);
    end
    chk("rst_rdy_m1", 32'(s_ready_w[1]), 32'd1);
    chk("rst_rdy_m2", 32'(s_ready_w[2]), 32'd0);
    chk("rst_rdy_m3", 32'(s_ready_w[3]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #3;
    for (int m = 1; m < 4; m++) chk("post_rst_rdy", 32'(s_ready_w[m]), 32'd1);

    // Forward register: 1-cycle latency, last of 8 beats leaves on cycle 8
    stream("t1_fwd", 1, 16'h0001, 8, 0, 100, cyc, mocc);
    chk("t1_cycles", 32'(cyc), 32'd9);
    chk("t1_occ",    32'(mocc), 32'd1);

    // Full slice with a 3-cycle stall: two beats held, stream ends on cycle 19
    stream("t2_full", 3, 16'h00A0, 16, 1, 100, cyc, mocc);
    chk("t2_cycles", 32'(cyc), 32'd20);
    chk("t2_occ",    32'(mocc), 32'd2);

    // Skid with 1010 ready: beat k leaves on cycle 2k
    stream("t3_skid", 2, 16'h0300, 16, 2, 100, cyc, mocc);
    chk("t3_cycles", 32'(cyc), 32'd31);
    chk("t3_occ",    32'(mocc), 32'd1);

    // Full throughput when both sides always ready
    for (int m = 0; m < 4; m++) begin
      stream("tput", m, 16'(16'h1000 * m), 16, 0, 100, cyc, mocc);
      chk("tput_cycles", 32'(cyc), (m == 1 || m == 3) ? 32'd17 : 32'd16);
      chk("tput_occ",    32'(mocc), (m == 1 || m == 3) ? 32'd1 : 32'd0);
    end

    // Random valid/ready, 2500 beats per mode
    for (int m = 0; m < 4; m++) begin
      stream("rnd", m, 16'(16'h4000 + 16'h100 * m), 2500, 3, 50, cyc, mocc);
      chk("rnd_occ_limit", 32'(mocc <= ((m == 3) ? 2 : (m == 0 ? 0 : 1))), 32'd1);
    end

    // Reset with two beats held in the full slice
    @(posedge clk); #1;
    s_valid[3] = 1'b1; s_data[3] = 16'h0055; s_user[3] = 4'h0; s_last[3] = 1'b0;
    m_ready[3] = 1'b0;
    @(posedge clk); #1;
    s_data[3] = 16'h0066;
    @(posedge clk); #1;
    s_valid[3] = 1'b0; s_data[3] = 16'hDEAD;
    #2;
    chk("t5_occ2",  32'(occ_w[7:6]), 32'd2);
    chk("t5_rdy0",  32'(s_ready_w[3]), 32'd0);
    chk("t5_vld1",  32'(m_valid_w[3]), 32'd1);
    chk("t5_head",  32'(m_data_w[63:48]), 32'h55);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready[3] = 1'b1;
    #2;
    chk("t5_rst_vld",  32'(m_valid_w[3]), 32'd0);
    chk("t5_rst_occ",  32'(occ_w[7:6]), 32'd0);
    chk("t5_rst_rdy",  32'(s_ready_w[3]), 32'd0);
    chk("t5_rst_data", 32'(m_data_w[63:48]), 32'd0);
    @(posedge clk); #3;
    chk("t5_post_rdy", 32'(s_ready_w[3]), 32'd1);
    chk("t5_post_vld", 32'(m_valid_w[3]), 32'd0);
    chk("t5_post_occ", 32'(occ_w[7:6]), 32'd0);
    @(posedge clk); #3;
    chk("t5_post_vld2", 32'(m_valid_w[3]), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
